decimation: RTL and testbench

DECIMATION -- requirements
Module: decimation

---
 rtl/decimation_if.sv | 36 +++
 rtl/decimation.sv | 139 +++++++++++++
 tb/tb_decimation.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decimation_if.sv
// Bus between the ADC capture path, the decimator and the downstream FIFO.
// The capture/FIFO side (master) drives ena, dataIn and full; the decimator
// (slave) drives the write strobe, the decimated word and the drop status.
interface decimation_if #(
    parameter int DATA_WIDTH = 14
) ();

    logic                  ena;       // arm request, stream valid from now on
    logic [DATA_WIDTH-1:0] dataIn;    // offset-binary ADC sample, one per clk
    logic                  full;      // downstream FIFO full flag
    logic                  wr_en;     // one-cycle FIFO write strobe
    logic [DATA_WIDTH-1:0] dec_data;  // decimated sample, offset-binary
    logic                  overflow;  // sticky: a decimated word was dropped
    logic [7:0]            drop_cnt;  // saturating count of dropped words

    modport master (
        output ena,
        output dataIn,
        output full,
        input  wr_en,
        input  dec_data,
        input  overflow,
        input  drop_cnt
    );

    modport slave (
        input  ena,
        input  dataIn,
        input  full,
        output wr_en,
        output dec_data,
        output overflow,
        output drop_cnt
    );

endinterface

// File: rtl/decimation.sv
// Boxcar decimator: averages N = 2^RATE_LOG2 consecutive ADC samples and
// writes one averaged word per frame into a downstream FIFO.
//
// Handshake: wr_en is a single-cycle write strobe qualified by the FIFO's
// full flag, which acts as an inverted ready. full is looked at only on the
// last sample of a frame; if it is high then, the word is dropped (counted
// and flagged), never retried, because the ADC sample rate cannot be stalled.
module decimation #(
    parameter int RATE_LOG2  = 4,
    parameter int DATA_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    decimation_if.slave          bus,
    output logic                 dbg_run,    // FSM state: 1 = RUN, 0 = IDLE
    output logic [RATE_LOG2-1:0] dbg_phase   // position inside current frame
);

    localparam int ACC_W = DATA_WIDTH + RATE_LOG2;
    localparam logic [RATE_LOG2-1:0] PHASE_LAST = {RATE_LOG2{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    run;
    logic                    frame_end;
    logic [RATE_LOG2-1:0]    phase;

    logic [DATA_WIDTH-1:0]   sample_tc;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [DATA_WIDTH-1:0]   sum_top;

    logic                    wr_en_r;
    logic [DATA_WIDTH-1:0]   dec_data_r;
    logic                    overflow_r;
    logic [7:0]              drop_cnt_r;

    // FSM state register; reset wins over everything, including ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: arm once on ena, then stay in RUN until reset.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ena) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: running flag and last-sample-of-frame marker.
    always_comb begin
        run       = (state == RUN);
        frame_end = (state == RUN) && (phase == PHASE_LAST);
    end

    // Phase counter; wraps naturally because N is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (run) begin
            phase <= phase + RATE_LOG2'(1);
        end
    end

    // Offset-binary to two's complement, sign-extend, running sum and the
    // floor(sum / N) result taken as the top bits of the sum.
    always_comb begin
        sample_tc  = {~bus.dataIn[DATA_WIDTH-1], bus.dataIn[DATA_WIDTH-2:0]};
        sample_ext = {{RATE_LOG2{sample_tc[DATA_WIDTH-1]}}, sample_tc};
        sum        = acc + sample_ext;
        sum_top    = sum[ACC_W-1:RATE_LOG2];
    end

    // Accumulator: first sample of a frame loads, the rest add.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (run) begin
            if (phase == '0) begin
                acc <= sample_ext;
            end else begin
                acc <= sum;
            end
        end
    end

    // Output word: captured at every frame end, even when it is dropped,
    // and returned to offset-binary by flipping the MSB back.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_data_r <= '0;
        end else if (frame_end) begin
            dec_data_r <= {~sum_top[DATA_WIDTH-1], sum_top[DATA_WIDTH-2:0]};
        end
    end

    // Write strobe: one cycle after a frame end when the FIFO had room.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r <= 1'b0;
        end else begin
            wr_en_r <= frame_end && !bus.full;
        end
    end

    // Drop bookkeeping: sticky flag and saturating counter, cleared by reset only.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else if (frame_end && bus.full) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 8'hFF) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    assign bus.wr_en    = wr_en_r;
    assign bus.dec_data = dec_data_r;
    assign bus.overflow = overflow_r;
    assign bus.drop_cnt = drop_cnt_r;
    assign dbg_run      = run;
    assign dbg_phase    = phase;

endmodule

// File: tb/tb_decimation.sv
// Bench for the boxcar decimator: table-driven pattern vectors, directed
// corner sequences and a randomized run, all checked every cycle against a
// frame-level averaging model.
module tb_decimation;

    localparam int DW = 14;
    localparam int RL = 4;
    localparam int N  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decimation_if #(.DATA_WIDTH(DW)) bus ();
    logic          dbg_run;
    logic [RL-1:0] dbg_phase;

    decimation #(.RATE_LOG2(RL), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_run   (dbg_run),
        .dbg_phase (dbg_phase)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit            m_armed;
    int            m_frame[$];
    logic          m_wr;
    logic [DW-1:0] m_dec;
    logic          m_ov;
    int            m_drops;
    logic [DW-1:0] exp_q[$];

    function automatic int floor_div_n(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [DW-1:0] d, input logic f);
        int total;
        int avg;
        m_wr = 1'b0;
        if (r) begin
            m_armed = 0;
            m_frame.delete();
            m_dec   = '0;
            m_ov    = 1'b0;
            m_drops = 0;
            exp_q.delete();
        end else if (!m_armed) begin
            if (e) m_armed = 1;
        end else begin
            m_frame.push_back(int'(d) - 8192);
            if (m_frame.size() == N) begin
                total = 0;
                foreach (m_frame[i]) total += m_frame[i];
                avg   = floor_div_n(total);
                m_dec = DW'(avg + 8192);
                if (f) begin
                    m_ov = 1'b1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_wr = 1'b1;
                    exp_q.push_back(m_dec);
                end
                m_frame.delete();
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("wr_en",    32'(bus.wr_en),    32'(m_wr));
        check("dec_data", 32'(bus.dec_data), 32'(m_dec));
        check("overflow", 32'(bus.overflow), 32'(m_ov));
        check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
        check("run",      32'(dbg_run),      32'(m_armed));
        check("phase",    32'(dbg_phase),    32'(m_frame.size()));
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write actual=%0h required=none", bus.dec_data);
            end else begin
                check("sb_word", 32'(bus.dec_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic r, input logic e, input logic [DW-1:0] d, input logic f);
        @(negedge clk);
        rst        = r;
        bus.ena    = e;
        bus.dataIn = d;
        bus.full   = f;
        @(posedge clk);
        model_step(r, e, d, f);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic [DW-1:0] a;     // sample on even phases (phase 0 first)
        logic [DW-1:0] b;     // sample on odd phases
        logic [DW-1:0] exp;   // averaged word
    } vec_t;

    vec_t vecs[5];

    initial begin
        int wr_count;
        int first_wr;
        int second_wr;
        logic saw_wr;

        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.dataIn = '0;
        bus.full   = 1'b0;
        model_step(1'b1, 1'b0, '0, 1'b0);

        vecs[0] = '{"mid_scale",  14'h2000, 14'h2000, 14'h2000};
        vecs[1] = '{"pos_full",   14'h3FFF, 14'h3FFF, 14'h3FFF};
        vecs[2] = '{"neg_full",   14'h0000, 14'h0000, 14'h0000};
        vecs[3] = '{"alternate",  14'h3FFF, 14'h0000, 14'h1FFF};
        vecs[4] = '{"pm_one",     14'h2001, 14'h1FFF, 14'h2000};

        do_reset();
        check("reset_wr_en",    32'(bus.wr_en),    32'd0);
        check("reset_dec_data", 32'(bus.dec_data), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        check("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);

        // Pattern vectors: two frames each, ena toggled randomly while running.
        foreach (vecs[v]) begin
            do_reset();
            tick(1'b0, 1'b1, vecs[v].a, 1'b0);
            wr_count  = 0;
            first_wr  = 0;
            second_wr = 0;
            for (int i = 1; i <= 2 * N; i++) begin
                tick(1'b0, 1'($urandom_range(0, 1)), (i % 2 == 1) ? vecs[v].a : vecs[v].b, 1'b0);
                if (bus.wr_en === 1'b1) begin
                    wr_count++;
                    if (wr_count == 1) first_wr = i;
                    if (wr_count == 2) second_wr = i;
                    check($sformatf("%s_word", vecs[v].name), 32'(bus.dec_data), 32'(vecs[v].exp));
                end
            end
            check($sformatf("%s_writes", vecs[v].name), 32'(wr_count), 32'd2);
            check($sformatf("%s_first_at", vecs[v].name), 32'(first_wr), 32'd16);
            check($sformatf("%s_second_at", vecs[v].name), 32'(second_wr), 32'd32);
        end

        // One frame meets full at its last sample: dropped, next frame writes.
        do_reset();
        tick(1'b0, 1'b1, 14'h2000, 1'b0);
        saw_wr = 1'b0;
        for (int p = 0; p < N; p++) begin
            tick(1'b0, 1'b0, 14'h2000, (p == 3) || (p == N - 1));
            if (bus.wr_en === 1'b1) saw_wr = 1'b1;
        end
        check("drop_no_write", 32'(saw_wr),       32'd0);
        check("drop_overflow", 32'(bus.overflow), 32'd1);
        check("drop_count",    32'(bus.drop_cnt), 32'd1);
        check("drop_word",     32'(bus.dec_data), 32'h2000);
        wr_count = 0;
        for (int p = 0; p < N; p++) begin
            tick(1'b0, 1'b0, 14'h3FFF, p == 5);
            if (bus.wr_en === 1'b1) begin
                wr_count++;
                check("after_drop_word", 32'(bus.dec_data), 32'h3FFF);
            end
        end
        check("after_drop_writes",   32'(wr_count),     32'd1);
        check("after_drop_overflow", 32'(bus.overflow), 32'd1);
        check("after_drop_count",    32'(bus.drop_cnt), 32'd1);

        // Reset at phase 7 clears everything; idle until re-armed.
        do_reset();
        tick(1'b0, 1'b1, 14'h2000, 1'b0);
        for (int p = 0; p < N; p++) tick(1'b0, 1'b0, 14'h2000, p == N - 1);
        for (int p = 0; p < 7; p++) tick(1'b0, 1'b0, 14'h3FFF, 1'b0);
        check("mid_rst_phase", 32'(dbg_phase), 32'd7);
        tick(1'b1, 1'b0, 14'h3FFF, 1'b0);
        check("mid_rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("mid_rst_dec_data", 32'(bus.dec_data), 32'd0);
        check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
        check("mid_rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        saw_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 14'h3FFF, 1'b0);
            if (bus.wr_en === 1'b1) saw_wr = 1'b1;
        end
        check("idle_no_write", 32'(saw_wr), 32'd0);
        tick(1'b0, 1'b1, 14'h3FFF, 1'b0);
        wr_count = 0;
        for (int p = 0; p < N; p++) begin
            tick(1'b0, 1'b0, 14'h0000, 1'b0);
            if (bus.wr_en === 1'b1) begin
                wr_count++;
                check("rearm_word", 32'(bus.dec_data), 32'h0000);
            end
        end
        check("rearm_writes", 32'(wr_count), 32'd1);

        // ena together with rst is ignored; ena on the next edge arms.
        tick(1'b1, 1'b1, 14'h2000, 1'b0);
        check("ena_with_rst_idle", 32'(dbg_run), 32'd0);
        tick(1'b0, 1'b1, 14'h2000, 1'b0);
        check("ena_after_rst_run", 32'(dbg_run), 32'd1);
        for (int p = 0; p < N; p++) tick(1'b0, 1'b0, 14'h2000, 1'b0);
        check("ena_after_rst_wr", 32'(bus.wr_en), 32'd1);

        // Drop counter saturation.
        do_reset();
        tick(1'b0, 1'b1, 14'h0000, 1'b1);
        for (int i = 0; i < 260 * N; i++) tick(1'b0, 1'b0, DW'($urandom_range(0, 16383)), 1'b1);
        check("sat_drop_cnt", 32'(bus.drop_cnt), 32'd255);
        check("sat_overflow", 32'(bus.overflow), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0,
                 DW'($urandom_range(0, 16383)), $urandom_range(0, 3) == 0);
        end

        check("sb_left_over", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
